// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: memory-op codes, FSM state
// encodings and the common zero constants.
package mem_stage_pkg;

  localparam logic [1:0] MemRW_Idle  = 2'b00;
  localparam logic [1:0] MemRW_Read  = 2'b01;
  localparam logic [1:0] MemRW_Write = 2'b10;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [31:0] ZeroData     = 32'h0000_0000;
  localparam logic [31:0] ZeroDataAddr = 32'h0000_0000;

endpackage

// File: rtl/mem_stage_timeout_cnt.sv
// Bus-access watchdog: counts BUSY cycles without ack and flags the cycle in
// which the access must be abandoned. A TIMEOUT of 0 never expires.
module mem_timeout_cnt #(
  parameter int TIMEOUT = 255,
  parameter int CW      = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [CW-1:0] TERM = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (en)
      cnt <= cnt + CW'(1);
  end

  assign expired = (TIMEOUT != 0) && (cnt == TERM);

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues loads/stores on a single-outstanding req/ack bus,
// stalls the pipe while an access is in flight, and forms the write-back triple.
module mem_stage #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int REG_AW  = 5,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mem_memrw,
  input  logic [ADDR_W-1:0] mem_memaddr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic [REG_AW-1:0] mem_waddr,
  input  logic              mem_we,
  input  logic              wb_hold,
  output logic [DATA_W-1:0] wb_wdata,
  output logic [REG_AW-1:0] wb_waddr,
  output logic              wb_we,
  output logic              stall_req,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              bus_err
);

  import mem_stage_pkg::*;

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  logic [1:0]        state;
  logic              is_access;
  logic              aligned;
  logic              op_read;
  logic              err_flag;
  logic [DATA_W-1:0] rd_data;
  logic              held;
  logic [DATA_W-1:0] hold_wdata;
  logic [REG_AW-1:0] hold_waddr;
  logic              hold_we;
  logic [DATA_W-1:0] done_wdata;
  logic              done_we;
  logic              cnt_clr;
  logic              cnt_en;
  logic              expired;

  assign is_access  = (mem_memrw == MemRW_Read) || (mem_memrw == MemRW_Write);
  assign aligned    = (mem_memaddr[1:0] == 2'b00);
  assign done_wdata = op_read ? rd_data : mem_wdata;
  assign done_we    = mem_we & ~err_flag;
  assign cnt_clr    = (state == ST_IDLE);
  assign cnt_en     = (state == ST_BUSY) && !bus_ack;

  mem_timeout_cnt #(
    .TIMEOUT (TIMEOUT),
    .CW      (CW)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      bus_err    <= 1'b0;
      rd_data    <= '0;
      op_read    <= 1'b0;
      err_flag   <= 1'b0;
      held       <= 1'b0;
      hold_wdata <= '0;
      hold_waddr <= '0;
      hold_we    <= 1'b0;
    end else begin
      bus_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          err_flag <= 1'b0;
          held     <= 1'b0;
          if (is_access) begin
            op_read <= (mem_memrw == MemRW_Read);
            if (aligned) begin
              bus_req   <= 1'b1;
              bus_we    <= (mem_memrw == MemRW_Write);
              bus_addr  <= mem_memaddr;
              bus_wdata <= mem_wdata;
              state     <= ST_BUSY;
            end else begin
              bus_err  <= 1'b1;
              err_flag <= 1'b1;
              state    <= ST_DONE;
            end
          end
        end
        // Ack outranks the watchdog, so a completion in the last allowed cycle succeeds.
        ST_BUSY: begin
          if (bus_ack) begin
            bus_req <= 1'b0;
            if (op_read)
              rd_data <= bus_rdata;
            state <= ST_DONE;
          end else if (expired) begin
            bus_req  <= 1'b0;
            bus_err  <= 1'b1;
            err_flag <= 1'b1;
            state    <= ST_DONE;
          end
        end
        // The first held edge snapshots the result so it survives EX/MEM moving on.
        ST_DONE: begin
          if (wb_hold) begin
            if (!held) begin
              held       <= 1'b1;
              hold_wdata <= done_wdata;
              hold_waddr <= mem_waddr;
              hold_we    <= done_we;
            end
          end else begin
            held     <= 1'b0;
            err_flag <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    stall_req = 1'b0;
    wb_wdata  = mem_wdata;
    wb_waddr  = mem_waddr;
    wb_we     = 1'b0;
    case (state)
      ST_IDLE: begin
        stall_req = is_access;
        wb_we     = is_access ? 1'b0 : mem_we;
      end
      ST_BUSY: begin
        stall_req = 1'b1;
      end
      ST_DONE: begin
        if (held) begin
          wb_wdata = hold_wdata;
          wb_waddr = hold_waddr;
          wb_we    = hold_we;
        end else begin
          wb_wdata = done_wdata;
          wb_we    = done_we;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: each access pushes its expected write-back
// triple, which is popped and compared when the stage reaches its result cycle.
module tb_mem_stage;

  localparam int TO = 4;

  logic        clk;
  logic        rst;
  logic [1:0]  mem_memrw;
  logic [31:0] mem_memaddr;
  logic [31:0] mem_wdata;
  logic [4:0]  mem_waddr;
  logic        mem_we;
  logic        wb_hold;
  logic [31:0] wb_wdata;
  logic [4:0]  wb_waddr;
  logic        wb_we;
  logic        stall_req;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        bus_err;

  typedef struct packed {
    logic [31:0] wdata;
    logic [4:0]  waddr;
    logic        we;
    logic        chk_data;
  } wb_t;

  wb_t sb_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  mem_stage #(
    .DATA_W (32),
    .ADDR_W (32),
    .REG_AW (5),
    .TIMEOUT(TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_memrw  (mem_memrw),
    .mem_memaddr(mem_memaddr),
    .mem_wdata  (mem_wdata),
    .mem_waddr  (mem_waddr),
    .mem_we     (mem_we),
    .wb_hold    (wb_hold),
    .wb_wdata   (wb_wdata),
    .wb_waddr   (wb_waddr),
    .wb_we      (wb_we),
    .stall_req  (stall_req),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_ack    (bus_ack),
    .bus_rdata  (bus_rdata),
    .bus_err    (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic driveIdle(input logic [1:0] op, input logic [31:0] wd, input logic [4:0] wa, input logic we);
    mem_memrw   = op;
    mem_memaddr = 32'h0;
    mem_wdata   = wd;
    mem_waddr   = wa;
    mem_we      = we;
  endtask

  // One cycle with a non-access op; outputs must follow the inputs combinationally.
  task automatic checkIdle(input string tag, input logic [1:0] op, input logic [31:0] wd,
                           input logic [4:0] wa, input logic we);
    @(posedge clk); #1;
    driveIdle(op, wd, wa, we);
    #1;
    checkOutput({tag, "_wdata"}, wb_wdata, wd);
    checkOutput({tag, "_waddr"}, 32'(wb_waddr), 32'(wa));
    checkOutput({tag, "_we"}, 32'(wb_we), 32'(we));
    @(negedge clk);
    checkOutput({tag, "_stall"}, 32'(stall_req), 32'd0);
    checkOutput({tag, "_req"}, 32'(bus_req), 32'd0);
  endtask

  // One complete access. ack_cycle = BUSY cycle carrying the ack (0 = never).
  task automatic applyStimulus(input string tag, input logic [1:0] op, input logic [31:0] addr,
                               input logic [31:0] wd, input logic [4:0] wa, input logic we,
                               input int ack_cycle, input logic [31:0] rdata, input bit hold);
    wb_t exp;
    wb_t got_exp;
    bit  misal;
    bit  tmo;
    int  exp_req;
    int  stall_n;
    int  req_n;
    int  err_n;
    int  busy_n;
    bit  done;

    misal   = (addr[1:0] != 2'b00);
    tmo     = !misal && (ack_cycle == 0 || ack_cycle > TO);
    exp_req = misal ? 0 : (tmo ? TO : ack_cycle);
    exp.wdata    = (op == 2'b01) ? rdata : wd;
    exp.waddr    = wa;
    exp.we       = we & ~(misal | tmo);
    exp.chk_data = !(misal | tmo);

    @(posedge clk); #1;
    mem_memrw   = op;
    mem_memaddr = addr;
    mem_wdata   = wd;
    mem_waddr   = wa;
    mem_we      = we;
    wb_hold     = hold;
    bus_ack     = 1'b0;
    sb_q.push_back(exp);

    stall_n = 0; req_n = 0; err_n = 0; busy_n = 0; done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (bus_err) err_n++;
      if (bus_req) begin
        req_n++;
        busy_n++;
        checkOutput({tag, "_bus_addr"}, bus_addr, addr);
        checkOutput({tag, "_bus_we"}, 32'(bus_we), 32'(op == 2'b10));
        if (op == 2'b10) checkOutput({tag, "_bus_wdata"}, bus_wdata, wd);
      end
      if (stall_req) begin
        stall_n++;
      end else if (stall_n > 0) begin
        done    = 1;
        got_exp = sb_q.pop_front();
        if (got_exp.chk_data) checkOutput({tag, "_wb_wdata"}, wb_wdata, got_exp.wdata);
        checkOutput({tag, "_wb_waddr"}, 32'(wb_waddr), 32'(got_exp.waddr));
        checkOutput({tag, "_wb_we"}, 32'(wb_we), 32'(got_exp.we));
      end
      if (!done) begin
        if (bus_req && busy_n == ack_cycle) begin
          bus_ack   = 1'b1;
          bus_rdata = rdata;
        end
        @(posedge clk); #1;
        bus_ack   = 1'b0;
        bus_rdata = 32'h0BAD_0BAD;
      end
    end
    if (!done) begin
      checkOutput({tag, "_done_seen"}, 32'd0, 32'd1);
      if (sb_q.size() > 0) void'(sb_q.pop_front());
    end

    checkOutput({tag, "_stall_cycles"}, 32'(stall_n), 32'(1 + exp_req));
    checkOutput({tag, "_req_cycles"}, 32'(req_n), 32'(exp_req));
    checkOutput({tag, "_err_pulses"}, 32'(err_n), 32'(misal | tmo));

    if (hold) begin
      @(posedge clk); #1;
      mem_wdata = ~wd;
      mem_waddr = ~wa;
      mem_we    = ~we;
      @(negedge clk);
      if (exp.chk_data) checkOutput({tag, "_hold_wdata"}, wb_wdata, exp.wdata);
      checkOutput({tag, "_hold_waddr"}, 32'(wb_waddr), 32'(exp.waddr));
      checkOutput({tag, "_hold_we"}, 32'(wb_we), 32'(exp.we));
      checkOutput({tag, "_hold_stall"}, 32'(stall_req), 32'd0);
      wb_hold = 1'b0;
    end

    @(posedge clk); #1;
    driveIdle(2'b00, 32'h0, 5'd0, 1'b0);
    @(negedge clk);
    checkOutput({tag, "_after_req"}, 32'(bus_req), 32'd0);
    checkOutput({tag, "_after_err"}, 32'(bus_err), 32'd0);
    checkOutput({tag, "_after_stall"}, 32'(stall_req), 32'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no_finish expected finish");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    rst       = 1'b0;
    wb_hold   = 1'b0;
    bus_ack   = 1'b0;
    bus_rdata = 32'h0;
    driveIdle(2'b00, 32'h0, 5'd0, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    checkOutput("rst_bus_req", 32'(bus_req), 32'd0);
    checkOutput("rst_bus_we", 32'(bus_we), 32'd0);
    checkOutput("rst_bus_err", 32'(bus_err), 32'd0);
    checkOutput("rst_bus_addr", bus_addr, 32'h0);
    checkOutput("rst_bus_wdata", bus_wdata, 32'h0);
    rst = 1'b1;

    checkIdle("idle_pass", 2'b00, 32'h0000_1234, 5'd5, 1'b1);
    checkIdle("idle_11", 2'b11, 32'hA5A5_0001, 5'd17, 1'b1);
    checkIdle("idle_we0", 2'b00, 32'h7777_8888, 5'd31, 1'b0);

    applyStimulus("load", 2'b01, 32'h100, 32'h55, 5'd3, 1'b1, 2, 32'hDEAD_BEEF, 1'b0);
    applyStimulus("store", 2'b10, 32'h200, 32'hCAFE_F00D, 5'd9, 1'b0, 1, 32'h1111_2222, 1'b0);
    applyStimulus("misal", 2'b01, 32'h102, 32'h0, 5'd4, 1'b1, 1, 32'h3333_4444, 1'b0);
    checkIdle("misal_idle", 2'b00, 32'h0000_00AA, 5'd6, 1'b1);
    applyStimulus("tmo", 2'b01, 32'h300, 32'h0, 5'd7, 1'b1, 0, 32'h0, 1'b0);
    applyStimulus("tmo_ack4", 2'b01, 32'h304, 32'h0, 5'd8, 1'b1, 4, 32'h0123_4567, 1'b0);
    applyStimulus("hold_ld", 2'b01, 32'h400, 32'h0, 5'd12, 1'b1, 1, 32'h89AB_CDEF, 1'b1);
    applyStimulus("hold_st", 2'b10, 32'h404, 32'h5555_AAAA, 5'd13, 1'b1, 3, 32'h0, 1'b1);

    // Reset dropped in the middle of a BUSY access, away from any clock edge.
    @(posedge clk); #1;
    mem_memrw   = 2'b01;
    mem_memaddr = 32'h500;
    mem_waddr   = 5'd2;
    mem_we      = 1'b1;
    @(posedge clk); #1;
    checkOutput("rstmid_req_before", 32'(bus_req), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("rstmid_req_async", 32'(bus_req), 32'd0);
    checkOutput("rstmid_addr_async", bus_addr, 32'h0);
    driveIdle(2'b00, 32'h0000_0BEE, 5'd21, 1'b1);
    #2;
    rst = 1'b1;
    @(posedge clk); #1;
    bus_ack   = 1'b1;
    bus_rdata = 32'hFEED_FACE;
    @(negedge clk);
    checkOutput("late_ack_stall", 32'(stall_req), 32'd0);
    checkOutput("late_ack_wdata", wb_wdata, 32'h0000_0BEE);
    @(posedge clk); #1;
    bus_ack = 1'b0;
    @(negedge clk);
    checkOutput("late_ack_req", 32'(bus_req), 32'd0);
    checkOutput("late_ack_err", 32'(bus_err), 32'd0);
    checkOutput("late_ack_stall2", 32'(stall_req), 32'd0);

    applyStimulus("post_rst_ld", 2'b01, 32'h600, 32'h0, 5'd22, 1'b1, 1, 32'h2468_ACE0, 1'b0);

    checkOutput("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
